// File: rtl/block_refill_memory.sv
// Backing main memory behind the data cache: serves whole-block refills and
// accepts whole-block write-backs, one word per cycle after a fixed latency.
module block_refill_memory #(
  parameter int DEPTH_LOG2 = 10,
  parameter int BLOCK_LOG2 = 2,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic [31:0] wdata_in,
  output logic        wdata_accept,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        xfer_last
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BEATS = 1 << BLOCK_LOG2;
  localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0]         LAT_LOAD  = LW'(LATENCY - 1);
  localparam logic [BLOCK_LOG2-1:0] LAST_BEAT = BLOCK_LOG2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t                r_state, w_nextState;
  logic [LW-1:0]         r_lat, w_nextLat;
  logic [BLOCK_LOG2-1:0] r_beat, w_nextBeat;
  logic [DEPTH_LOG2-1:0] r_base;
  logic                  r_write;
  logic [31:0]           r_rdata;
  logic                  w_accept, w_lastBeat, w_rdLoad, w_memWe;
  logic [DEPTH_LOG2-1:0] w_rdAddr, w_wrAddr;
  logic [31:0]           w_words [DEPTH];
  logic                  w_unusedAddr;

  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_lastBeat   = (r_beat == LAST_BEAT);
  assign w_wrAddr     = r_base + DEPTH_LOG2'(r_beat);
  assign w_memWe      = (r_state == XFER) && r_write && !reset;
  assign w_unusedAddr = ^{req_addr[31:DEPTH_LOG2], req_addr[BLOCK_LOG2-1:0]};

  // Words are stored XORed with their own index, so power-up-zero storage
  // reads back as mem[i] = i without any load sequence.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] r_word;
    always_ff @(posedge clk) begin
      if (w_memWe && (w_wrAddr == DEPTH_LOG2'(i))) begin
        r_word <= wdata_in ^ 32'(i);
      end
    end
    assign w_words[i] = r_word ^ 32'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // The refill word for the upcoming beat is fetched on the edge that enters it.
  always_comb begin
    w_nextState = r_state;
    w_nextLat   = r_lat;
    w_nextBeat  = r_beat;
    w_rdLoad    = 1'b0;
    w_rdAddr    = r_base;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_nextState = WAIT;
          w_nextLat   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (r_lat == '0) begin
          w_nextState = XFER;
          w_nextBeat  = '0;
          w_rdLoad    = !r_write;
          w_rdAddr    = r_base;
        end else begin
          w_nextLat = r_lat - 1'b1;
        end
      end
      XFER: begin
        if (w_lastBeat) begin
          w_nextState = IDLE;
        end else begin
          w_nextBeat = r_beat + 1'b1;
          w_rdLoad   = !r_write;
          w_rdAddr   = r_base + DEPTH_LOG2'(w_nextBeat);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat   <= '0;
      r_beat  <= '0;
      r_base  <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_lat  <= w_nextLat;
      r_beat <= w_nextBeat;
      if (w_accept) begin
        r_base  <= {req_addr[DEPTH_LOG2-1:BLOCK_LOG2], {BLOCK_LOG2{1'b0}}};
        r_write <= req_write;
      end
      if (w_rdLoad) r_rdata <= w_words[w_rdAddr];
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign rdata_valid  = (r_state == XFER) && !r_write;
  assign wdata_accept = (r_state == XFER) && r_write;
  assign xfer_last    = (r_state == XFER) && w_lastBeat;
  assign rdata        = r_rdata;

endmodule
